// File: rtl/vxu_lane_fu_issue_sched.sv
// ---------------------------------------------------------------------------
// vxu_lane_fu_issue_sched
//
// Per-lane issue scheduler in front of the lane functional-unit sequencer.
// Six unit classes issue here: VAU0, VAU1, VAU2, VGU, VSU share the single
// bank read port and are arbitrated round-robin; VLU only uses the write port
// and is granted whenever it is eligible. Each unit carries a busy counter so
// it cannot be re-issued while its previous operation is still counting down.
// Grants are combinational from registered state and the current requests,
// so an accepted request produces its expand_* pulse in the same cycle.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   stall                blocks every grant this cycle
//   <c>_req_val/rdy      request handshake per class (rdy = grant)
//   <c>_req_cnt          element count minus one
//   vau*_req_fn          function code, passed through on issue
//   vlu_req_ut/vsu_req_ut  0 = vector queue, 1 = microthread queue
//   expand_*             one-cycle issue pulses toward the sequencer
//   expand_vau*_fn       function code of the issuing op, 0 otherwise
//   expand_rcnt          count of the read-port issue, 0 if none
//   expand_wcnt          count of the VLU issue, 0 if none
//   idle                 no unit busy and no request valid
// ---------------------------------------------------------------------------
module vxu_lane_fu_issue_sched #(
    parameter int SZ_BVLEN  = 8,
    parameter int W_VAU0_FN = 2,
    parameter int W_VAU1_FN = 11,
    parameter int W_VAU2_FN = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,

    input  logic                 vau0_req_val,
    output logic                 vau0_req_rdy,
    input  logic [SZ_BVLEN-1:0]  vau0_req_cnt,
    input  logic [W_VAU0_FN-1:0] vau0_req_fn,

    input  logic                 vau1_req_val,
    output logic                 vau1_req_rdy,
    input  logic [SZ_BVLEN-1:0]  vau1_req_cnt,
    input  logic [W_VAU1_FN-1:0] vau1_req_fn,

    input  logic                 vau2_req_val,
    output logic                 vau2_req_rdy,
    input  logic [SZ_BVLEN-1:0]  vau2_req_cnt,
    input  logic [W_VAU2_FN-1:0] vau2_req_fn,

    input  logic                 vgu_req_val,
    output logic                 vgu_req_rdy,
    input  logic [SZ_BVLEN-1:0]  vgu_req_cnt,

    input  logic                 vlu_req_val,
    output logic                 vlu_req_rdy,
    input  logic [SZ_BVLEN-1:0]  vlu_req_cnt,
    input  logic                 vlu_req_ut,

    input  logic                 vsu_req_val,
    output logic                 vsu_req_rdy,
    input  logic [SZ_BVLEN-1:0]  vsu_req_cnt,
    input  logic                 vsu_req_ut,

    output logic                 expand_vau0,
    output logic                 expand_vau1,
    output logic                 expand_vau2,
    output logic                 expand_utaq,
    output logic                 expand_vldq,
    output logic                 expand_utldq,
    output logic                 expand_vsdq,
    output logic                 expand_utsdq,
    output logic [W_VAU0_FN-1:0] expand_vau0_fn,
    output logic [W_VAU1_FN-1:0] expand_vau1_fn,
    output logic [W_VAU2_FN-1:0] expand_vau2_fn,
    output logic [SZ_BVLEN-1:0]  expand_rcnt,
    output logic [SZ_BVLEN-1:0]  expand_wcnt,
    output logic                 idle
);

    // Class indices: 0..4 are the read-port classes in round-robin order,
    // 5 is VLU which never competes for the read port.
    localparam logic [2:0] C_VSU = 3'd4;
    localparam int         N_CLS = 6;
    localparam logic [SZ_BVLEN-1:0] CNT_ONE = SZ_BVLEN'(1);

    logic [SZ_BVLEN-1:0] r_cnt [N_CLS];
    logic [N_CLS-1:0]    r_busy;
    logic [2:0]          r_last;

    logic [SZ_BVLEN-1:0] w_reqCnt [N_CLS];
    logic [N_CLS-1:0]    w_val;
    logic [N_CLS-1:0]    w_elig;
    logic [N_CLS-1:0]    w_grant;
    logic                w_rdFound;
    logic [2:0]          w_rdIdx;
    logic [3:0]          w_sum;
    logic [2:0]          w_scanIdx;

    assign w_val = {vlu_req_val, vsu_req_val, vgu_req_val,
                    vau2_req_val, vau1_req_val, vau0_req_val};

    assign w_reqCnt[0] = vau0_req_cnt;
    assign w_reqCnt[1] = vau1_req_cnt;
    assign w_reqCnt[2] = vau2_req_cnt;
    assign w_reqCnt[3] = vgu_req_cnt;
    assign w_reqCnt[4] = vsu_req_cnt;
    assign w_reqCnt[5] = vlu_req_cnt;

    // Reset is folded into eligibility so nothing is granted while it is high.
    assign w_elig = w_val & ~r_busy & {N_CLS{~stall & ~reset}};

    // Scan the read-port classes starting one past the last winner; the first
    // eligible one gets the port. VLU is granted on its own.
    always_comb begin
        w_grant   = '0;
        w_rdFound = 1'b0;
        w_rdIdx   = '0;
        w_sum     = '0;
        w_scanIdx = '0;
        for (int k = 1; k <= 5; k++) begin
            w_sum     = {1'b0, r_last} + 4'(k);
            w_scanIdx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : w_sum[2:0];
            if (!w_rdFound && w_elig[w_scanIdx]) begin
                w_grant[w_scanIdx] = 1'b1;
                w_rdFound          = 1'b1;
                w_rdIdx            = w_scanIdx;
            end
        end
        w_grant[5] = w_elig[5];
    end

    assign vau0_req_rdy = w_grant[0];
    assign vau1_req_rdy = w_grant[1];
    assign vau2_req_rdy = w_grant[2];
    assign vgu_req_rdy  = w_grant[3];
    assign vsu_req_rdy  = w_grant[4];
    assign vlu_req_rdy  = w_grant[5];

    assign expand_vau0  = w_grant[0];
    assign expand_vau1  = w_grant[1];
    assign expand_vau2  = w_grant[2];
    assign expand_utaq  = w_grant[3];
    assign expand_vsdq  = w_grant[4] & ~vsu_req_ut;
    assign expand_utsdq = w_grant[4] &  vsu_req_ut;
    assign expand_vldq  = w_grant[5] & ~vlu_req_ut;
    assign expand_utldq = w_grant[5] &  vlu_req_ut;

    assign expand_vau0_fn = w_grant[0] ? vau0_req_fn : '0;
    assign expand_vau1_fn = w_grant[1] ? vau1_req_fn : '0;
    assign expand_vau2_fn = w_grant[2] ? vau2_req_fn : '0;

    assign expand_rcnt = w_rdFound  ? w_reqCnt[w_rdIdx] : '0;
    assign expand_wcnt = w_grant[5] ? vlu_req_cnt       : '0;

    // A counter can only be nonzero while its busy flag is set, so the busy
    // flags alone tell us every counter has drained. During reset the state
    // is being cleared, so only the request valids matter.
    assign idle = ~(|w_val) & (reset | ~(|r_busy));

    // Busy tracking: a grant loads the count and marks the unit busy; the
    // counter then drains to zero and the busy flag drops one cycle later,
    // so an op with count n keeps its unit blocked for n+1 cycles after issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CLS; i++) begin
                r_cnt[i] <= '0;
            end
            r_busy <= '0;
            r_last <= C_VSU;
        end else begin
            for (int i = 0; i < N_CLS; i++) begin
                if (w_grant[i]) begin
                    r_cnt[i]  <= w_reqCnt[i];
                    r_busy[i] <= 1'b1;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i]  <= r_cnt[i] - CNT_ONE;
                end else begin
                    r_busy[i] <= 1'b0;
                end
            end
            if (w_rdFound) begin
                r_last <= w_rdIdx;
            end
        end
    end

endmodule

// File: tb/tb_vxu_lane_fu_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_vxu_lane_fu_issue_sched
//
// Table-driven bench for the lane issue scheduler. Each table row is one
// clock cycle of inputs plus the outputs expected in that cycle; the expected
// part is pushed to a scoreboard when the row is driven and popped when the
// outputs are sampled on the falling edge. A short hand-written sequence then
// measures how many cycles a drained unit takes to report idle.
// ---------------------------------------------------------------------------
module tb_vxu_lane_fu_issue_sched;

    localparam int SZ_BVLEN  = 8;
    localparam int W_VAU0_FN = 2;
    localparam int W_VAU1_FN = 11;
    localparam int W_VAU2_FN = 10;

    localparam logic [W_VAU0_FN-1:0] FN0 = 2'b10;
    localparam logic [W_VAU1_FN-1:0] FN1 = 11'h5A5;
    localparam logic [W_VAU2_FN-1:0] FN2 = 10'h2C3;

    // Bit order for rdy/val: {vlu, vsu, vgu, vau2, vau1, vau0}
    // Bit order for expand: {utsdq, vsdq, utldq, vldq, utaq, vau2, vau1, vau0}
    typedef struct packed {
        logic [5:0] rdy;
        logic [7:0] expand;
        logic [7:0] rcnt;
        logic [7:0] wcnt;
        logic       idle;
    } exp_t;

    typedef struct packed {
        logic            rst;
        logic            stall;
        logic [5:0]      val;
        logic            vluUt;
        logic            vsuUt;
        logic [5:0][7:0] cnt;
        exp_t            exp;
    } vec_t;

    logic clk;
    logic reset;
    logic stall;
    logic vau0ReqVal, vau1ReqVal, vau2ReqVal, vguReqVal, vluReqVal, vsuReqVal;
    logic vau0ReqRdy, vau1ReqRdy, vau2ReqRdy, vguReqRdy, vluReqRdy, vsuReqRdy;
    logic [SZ_BVLEN-1:0] vau0ReqCnt, vau1ReqCnt, vau2ReqCnt, vguReqCnt, vluReqCnt, vsuReqCnt;
    logic [W_VAU0_FN-1:0] vau0ReqFn;
    logic [W_VAU1_FN-1:0] vau1ReqFn;
    logic [W_VAU2_FN-1:0] vau2ReqFn;
    logic vluReqUt, vsuReqUt;
    logic expVau0, expVau1, expVau2, expUtaq, expVldq, expUtldq, expVsdq, expUtsdq;
    logic [W_VAU0_FN-1:0] expVau0Fn;
    logic [W_VAU1_FN-1:0] expVau1Fn;
    logic [W_VAU2_FN-1:0] expVau2Fn;
    logic [SZ_BVLEN-1:0] expRcnt, expWcnt;
    logic idle;

    int   checkCount;
    int   passCount;
    exp_t sbQ[$];
    vec_t vecs[$];

    vxu_lane_fu_issue_sched #(
        .SZ_BVLEN (SZ_BVLEN),
        .W_VAU0_FN(W_VAU0_FN),
        .W_VAU1_FN(W_VAU1_FN),
        .W_VAU2_FN(W_VAU2_FN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .vau0_req_val  (vau0ReqVal),
        .vau0_req_rdy  (vau0ReqRdy),
        .vau0_req_cnt  (vau0ReqCnt),
        .vau0_req_fn   (vau0ReqFn),
        .vau1_req_val  (vau1ReqVal),
        .vau1_req_rdy  (vau1ReqRdy),
        .vau1_req_cnt  (vau1ReqCnt),
        .vau1_req_fn   (vau1ReqFn),
        .vau2_req_val  (vau2ReqVal),
        .vau2_req_rdy  (vau2ReqRdy),
        .vau2_req_cnt  (vau2ReqCnt),
        .vau2_req_fn   (vau2ReqFn),
        .vgu_req_val   (vguReqVal),
        .vgu_req_rdy   (vguReqRdy),
        .vgu_req_cnt   (vguReqCnt),
        .vlu_req_val   (vluReqVal),
        .vlu_req_rdy   (vluReqRdy),
        .vlu_req_cnt   (vluReqCnt),
        .vlu_req_ut    (vluReqUt),
        .vsu_req_val   (vsuReqVal),
        .vsu_req_rdy   (vsuReqRdy),
        .vsu_req_cnt   (vsuReqCnt),
        .vsu_req_ut    (vsuReqUt),
        .expand_vau0   (expVau0),
        .expand_vau1   (expVau1),
        .expand_vau2   (expVau2),
        .expand_utaq   (expUtaq),
        .expand_vldq   (expVldq),
        .expand_utldq  (expUtldq),
        .expand_vsdq   (expVsdq),
        .expand_utsdq  (expUtsdq),
        .expand_vau0_fn(expVau0Fn),
        .expand_vau1_fn(expVau1Fn),
        .expand_vau2_fn(expVau2Fn),
        .expand_rcnt   (expRcnt),
        .expand_wcnt   (expWcnt),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts packed in class order: {vlu, vsu, vgu, vau2, vau1, vau0}
    function automatic logic [5:0][7:0] cnts(input logic [7:0] c0, input logic [7:0] c1,
                                             input logic [7:0] c2, input logic [7:0] cg,
                                             input logic [7:0] cs, input logic [7:0] cl);
        cnts = {cl, cs, cg, c2, c1, c0};
    endfunction

    function automatic vec_t mkVec(input logic rst, input logic stl, input logic [5:0] val,
                                   input logic lUt, input logic sUt, input logic [5:0][7:0] c,
                                   input logic [5:0] rdy, input logic [7:0] ex,
                                   input logic [7:0] rc, input logic [7:0] wc, input logic idl);
        vec_t v;
        v.rst = rst; v.stall = stl; v.val = val; v.vluUt = lUt; v.vsuUt = sUt; v.cnt = c;
        v.exp.rdy = rdy; v.exp.expand = ex; v.exp.rcnt = rc; v.exp.wcnt = wc; v.exp.idle = idl;
        return v;
    endfunction

    task automatic checkField(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] req);
        checkCount++;
        if (act === req) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s (vec %0d): actual=0x%0h required=0x%0h", name, idx, act, req);
        end
    endtask

    // Drive one row of inputs and record what the outputs must be this cycle
    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        stall      = v.stall;
        vau0ReqVal = v.val[0];
        vau1ReqVal = v.val[1];
        vau2ReqVal = v.val[2];
        vguReqVal  = v.val[3];
        vsuReqVal  = v.val[4];
        vluReqVal  = v.val[5];
        vau0ReqCnt = v.cnt[0];
        vau1ReqCnt = v.cnt[1];
        vau2ReqCnt = v.cnt[2];
        vguReqCnt  = v.cnt[3];
        vsuReqCnt  = v.cnt[4];
        vluReqCnt  = v.cnt[5];
        vluReqUt   = v.vluUt;
        vsuReqUt   = v.vsuUt;
        sbQ.push_back(v.exp);
    endtask

    // Pop the oldest expectation and compare it with the live outputs
    task automatic checkOutput(input int idx);
        exp_t e;
        if (sbQ.size() == 0) begin
            checkField("scoreboardEmpty", idx, 32'd1, 32'd0);
        end else begin
            e = sbQ.pop_front();
            checkField("rdy", idx,
                32'({vluReqRdy, vsuReqRdy, vguReqRdy, vau2ReqRdy, vau1ReqRdy, vau0ReqRdy}),
                32'(e.rdy));
            checkField("expand", idx,
                32'({expUtsdq, expVsdq, expUtldq, expVldq, expUtaq, expVau2, expVau1, expVau0}),
                32'(e.expand));
            checkField("rcnt", idx, 32'(expRcnt), 32'(e.rcnt));
            checkField("wcnt", idx, 32'(expWcnt), 32'(e.wcnt));
            checkField("idle", idx, 32'(idle), 32'(e.idle));
            checkField("vau0Fn", idx, 32'(expVau0Fn), 32'(e.expand[0] ? FN0 : '0));
            checkField("vau1Fn", idx, 32'(expVau1Fn), 32'(e.expand[1] ? FN1 : '0));
            checkField("vau2Fn", idx, 32'(expVau2Fn), 32'(e.expand[2] ? FN2 : '0));
        end
    endtask

    initial begin
        int idleAt;
        checkCount = 0;
        passCount  = 0;
        vau0ReqFn  = FN0;
        vau1ReqFn  = FN1;
        vau2ReqFn  = FN2;
        applyStimulus(mkVec(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, cnts(0,0,0,0,0,0),
                            6'b0, 8'h00, 8'd0, 8'd0, 1'b1));
        void'(sbQ.pop_front());

        // Reset, then round-robin among vau0/vau1/vau2 from vau0 priority
        vecs.push_back(mkVec(1,0,6'b000000,0,0,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,1));
        vecs.push_back(mkVec(1,0,6'b000111,0,0,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000111,0,0,cnts(0,0,0,0,0,0), 6'b000001,8'h01,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000111,0,0,cnts(0,0,0,0,0,0), 6'b000010,8'h02,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000111,0,0,cnts(0,0,0,0,0,0), 6'b000100,8'h04,8'd0,8'd0,0));
        // vau2 still busy for one cycle, then idle
        vecs.push_back(mkVec(0,0,6'b000000,0,0,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000000,0,0,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,1));
        // Occupancy: vau1 cnt=3 blocks through t+4; vau2 gets the port at t+1
        vecs.push_back(mkVec(0,0,6'b000110,0,0,cnts(0,3,1,0,0,0), 6'b000010,8'h02,8'd3,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000110,0,0,cnts(0,3,1,0,0,0), 6'b000100,8'h04,8'd1,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000010,0,0,cnts(0,3,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000010,0,0,cnts(0,3,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000010,0,0,cnts(0,3,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000010,0,0,cnts(0,3,0,0,0,0), 6'b000010,8'h02,8'd3,8'd0,0));
        // Concurrent VLU (ut=1, cnt=5) and VSU (ut=0, cnt=7)
        vecs.push_back(mkVec(0,0,6'b110000,1,0,cnts(0,0,0,0,7,5), 6'b110000,8'h60,8'd7,8'd5,0));
        // Stall two cycles with vgu valid, granted when stall drops
        vecs.push_back(mkVec(0,1,6'b001000,0,0,cnts(0,0,0,2,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,1,6'b001000,0,0,cnts(0,0,0,2,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b001000,0,0,cnts(0,0,0,2,0,0), 6'b001000,8'h08,8'd2,8'd0,0));
        // VLU frees at 13+5+2=20, VSU at 13+7+2=22 despite the stall
        vecs.push_back(mkVec(0,0,6'b110000,0,1,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b110000,0,1,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b110000,0,1,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b110000,0,1,cnts(0,0,0,0,0,0), 6'b100000,8'h10,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b010000,0,1,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b010000,0,1,cnts(0,0,0,0,0,0), 6'b010000,8'h80,8'd0,8'd0,0));
        // Reset mid-operation with vau0 cnt=200
        vecs.push_back(mkVec(0,0,6'b000001,0,0,cnts(200,0,0,0,0,0), 6'b000001,8'h01,8'd200,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000001,0,0,cnts(200,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(1,0,6'b000001,0,0,cnts(200,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000011,0,0,cnts(200,3,0,0,0,0), 6'b000001,8'h01,8'd200,8'd0,0));
        vecs.push_back(mkVec(0,0,6'b000010,0,0,cnts(0,3,0,0,0,0), 6'b000010,8'h02,8'd3,8'd0,0));
        vecs.push_back(mkVec(1,0,6'b000000,0,0,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,1));
        vecs.push_back(mkVec(0,0,6'b000000,0,0,cnts(0,0,0,0,0,0), 6'b000000,8'h00,8'd0,8'd0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(i);
        end

        // Idle latency: vau2 cnt=4 issued now must report idle 6 cycles later
        @(posedge clk);
        #1;
        reset = 1'b0; stall = 1'b0;
        vau2ReqVal = 1'b1; vau2ReqCnt = 8'd4;
        @(negedge clk);
        checkField("vau2Issue", 100, 32'(vau2ReqRdy), 32'd1);
        idleAt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            vau2ReqVal = 1'b0;
            @(negedge clk);
            if (idle && idleAt == 0) begin
                idleAt = k;
            end
        end
        checkField("idleLatency", 101, 32'(idleAt), 32'd6);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
